// File: rtl/addr_onehot_decoder.sv
// -----------------------------------------------------------------------------
// addr_onehot_decoder
//
// Decodes a 4-bit address index into a 15-bit one-hot select word and holds
// that word on AddrOut for DWELL cycles. After the hold it drives one all-zero
// gap cycle so that two consecutive selects never overlap (break-before-make).
// Index 15 has no select line. It is consumed and reported with a one-cycle
// AddrErr pulse.
//
// Parameters
//   DWELL      cycles each decoded word is held on AddrOut (legal 1..255)
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-low reset
//   AddrIn     address index, sampled only on an accepted handshake
//   AddrValid  requester presents a valid AddrIn
//   AddrReady  block accepts AddrIn this cycle (IDLE and Clear low)
//   Clear      synchronous abort of the current hold
//   AddrOut    registered one-hot (or all-zero) select word
//   Busy       high while a word is held or during the gap cycle
//   AddrErr    one-cycle pulse after an illegal index is accepted
// -----------------------------------------------------------------------------
module addr_onehot_decoder #(
    parameter int unsigned DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AddrIn,
    input  logic        AddrValid,
    output logic        AddrReady,
    input  logic        Clear,
    output logic [14:0] AddrOut,
    output logic        Busy,
    output logic        AddrErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter reload value: the first hold cycle is counted by the load itself.
    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 32'd1);

    // Index 0 maps to the top select line, index k (1..14) to line k-1.
    // Index 15 has no line and decodes to all zeros.
    function automatic logic [14:0] decode_onehot(input logic [3:0] idx);
        logic [14:0] word;
        word = 15'h0000;
        case (idx)
            4'd0:    word = 15'h4000;
            4'd15:   word = 15'h0000;
            default: word = 15'h0001 << (idx - 4'd1);
        endcase
        return word;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nxt_s;
    logic [14:0] addr_out_r;
    logic [14:0] addr_out_nxt_s;
    logic        addr_err_r;
    logic        addr_err_nxt_s;
    logic        ready_s;
    logic        accept_s;
    logic        legal_s;

    // Handshake qualification: Clear blocks acceptance, and nothing is
    // advertised while reset is asserted.
    always_comb begin
        ready_s  = rst && (state_r == ST_IDLE) && !Clear;
        accept_s = ready_s && AddrValid;
        legal_s  = (AddrIn != 4'd15);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (Clear || (cnt_r == 8'd0)) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and dwell-counter next values.
    always_comb begin
        addr_out_nxt_s = addr_out_r;
        cnt_nxt_s      = cnt_r;
        addr_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    addr_out_nxt_s = decode_onehot(AddrIn);
                    cnt_nxt_s      = DWELL_M1;
                end else if (accept_s) begin
                    // Illegal index: consumed, flagged, output stays zero.
                    addr_out_nxt_s = 15'h0000;
                    cnt_nxt_s      = 8'd0;
                    addr_err_nxt_s = 1'b1;
                end else begin
                    addr_out_nxt_s = 15'h0000;
                    cnt_nxt_s      = 8'd0;
                end
            end
            ST_HOLD: begin
                if (Clear || (cnt_r == 8'd0)) begin
                    addr_out_nxt_s = 15'h0000;
                    cnt_nxt_s      = 8'd0;
                end else begin
                    cnt_nxt_s      = cnt_r - 8'd1;
                end
            end
            ST_GAP: begin
                addr_out_nxt_s = 15'h0000;
                cnt_nxt_s      = 8'd0;
            end
            default: begin
                addr_out_nxt_s = 15'h0000;
                cnt_nxt_s      = 8'd0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            addr_out_r <= 15'h0000;
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            addr_out_r <= addr_out_nxt_s;
            addr_err_r <= addr_err_nxt_s;
        end
    end

    // Output mapping; Busy is a pure decode of the state register.
    always_comb begin
        AddrOut   = addr_out_r;
        AddrErr   = addr_err_r;
        Busy      = (state_r != ST_IDLE);
        AddrReady = ready_s;
    end

endmodule

// File: doc/addr_onehot_decoder.md
ADDR_ONEHOT_DECODER -- requirements
Module: addr_onehot_decoder

Interface
REQ-001 Parameter DWELL, default 4, cycles each decoded one-hot word is held on AddrOut (legal 1..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 AddrIn  input  4  address index to decode, sampled only on an accepted handshake.
REQ-005 AddrValid  input  1  requester has a valid AddrIn.
REQ-006 AddrReady  output  1  block accepts AddrIn this cycle.
REQ-007 Clear  input  1  synchronous abort of the current hold.
REQ-008 AddrOut  output  15  registered one-hot (or all-zero) select word.
REQ-009 Busy  output  1  high while a word is held or in the gap cycle.
REQ-010 AddrErr  output  1  one-cycle pulse flagging a rejected index.

Function
REQ-011 Mapping SHALL be: index 0 -> AddrOut[14]; index k (1..14) -> AddrOut[k-1]; exactly one bit set.
REQ-012 Index 15 SHALL be illegal: accepted (consumed), AddrErr high for exactly the next cycle, AddrOut stays 15'h0000, state stays IDLE.
REQ-013 FSM states SHALL be IDLE, HOLD, GAP.
REQ-014 AddrReady SHALL be high only in IDLE with Clear low; handshake completes on an edge where AddrValid and AddrReady are both high.
REQ-015 IDLE -> HOLD on a legal accept: at that edge AddrOut loads decoded word, dwell counter loads DWELL-1.
REQ-016 HOLD: AddrOut held constant; counter decrements each cycle; when counter is 0 at an edge, AddrOut <= 0 and state -> GAP.
REQ-017 Hold length SHALL be exactly DWELL cycles of AddrOut one-hot (DWELL=1 gives one cycle).
REQ-018 GAP: exactly one cycle of AddrOut = 0 and AddrReady = 0 (break-before-make), then -> IDLE.
REQ-019 Minimum spacing between accepts SHALL be DWELL+2 cycles; back-to-back requests give DWELL one-hot cycles, one zero cycle, one IDLE/accept cycle.
REQ-020 Busy SHALL equal (state != IDLE).
REQ-021 Clear high in HOLD: at that edge AddrOut <= 0, counter <= 0, state -> GAP.
REQ-022 Clear high in GAP or IDLE: no accept, AddrOut remains 0; GAP still proceeds to IDLE.
REQ-023 Clear and AddrValid high together in IDLE: Clear wins, request not consumed (AddrReady low).
REQ-024 AddrIn/AddrValid changes outside an accepting edge SHALL have no effect on AddrOut.
REQ-025 AddrOut SHALL never have more than one bit set in any cycle.
REQ-026 AddrErr SHALL be low in every cycle except the one after an illegal accept.

Reset
REQ-027 rst low at a rising edge SHALL force state IDLE, counter 0, AddrOut 15'h0000, AddrErr 0, Busy 0; AddrReady high from the first cycle after rst returns high.
REQ-028 rst low mid-HOLD SHALL override Clear and handshake; AddrOut zero the cycle after that edge, no GAP cycle required.

Verification
REQ-029 DWELL=4, accept AddrIn=0 -> AddrOut=15'h4000 for 4 cycles, 15'h0000 for 1 GAP cycle, AddrReady high next cycle.
REQ-030 Sweep AddrIn 1..14 -> AddrOut = 1<<(AddrIn-1) each, Busy high for 5 cycles per word, no AddrErr.
REQ-031 Accept AddrIn=15 -> AddrErr=1 one cycle, AddrOut=0, Busy=0, AddrReady high following cycle.
REQ-032 AddrIn=7 accepted, Clear pulsed on 2nd hold cycle -> AddrOut 15'h0040 for 2 cycles then 0, GAP, IDLE; Clear+AddrValid in IDLE -> no accept.
REQ-033 AddrValid held high with AddrIn=3 continuously, DWELL=1 -> pattern 15'h0004, 0, 0 repeating (accept every 3 cycles).
REQ-034 rst asserted during HOLD of AddrIn=14 -> AddrOut=0 next cycle, Busy=0; first post-reset accept of AddrIn=1 -> 15'h0001.
